prio_encoder8: RTL and testbench

Registered 8-to-3 priority encoder with request capture and a valid/ready output handshake. It performs the inverse of the team's 3-to-8 decoder: one-hot/multi-hot request lines in, 3-bit binary code out. Incoming requests are latched into a sticky pending register. The highest pending index is presented as a code, and its pending bit is retired when the code is handed off. It sits between interrupt or event sources and a consumer that acknowledges one event per handshake.

---
 rtl/prio_encoder8.sv | 76 +++++++
 tb/tb_prio_encoder8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder8.sv
// Registered 8-to-3 priority encoder: sticky request capture, highest-index
// selection and a valid/ready output stage that retires one index per handshake.
module prio_encoder8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       ovf,
    input  logic       ovf_clr
);

    logic [7:0] pend_q, pend_d;
    logic [2:0] code_q, code_d;
    logic       vld_q, vld_d;
    logic       ovf_q, ovf_d;

    logic       load;
    logic [2:0] sel;
    logic [7:0] take;
    logic       ovf_set;

    // Bit 7 has the highest priority; later iterations overwrite earlier ones.
    function automatic logic [2:0] hi_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    always_comb begin
        sel     = hi_idx(pend_q);
        load    = en && (!vld_q || out_ready) && (pend_q != 8'h00);
        take    = load ? (8'h01 << sel) : 8'h00;
        ovf_set = en && ((req & pend_q & ~take) != 8'h00);

        // A request on the bit being taken re-pends it (set wins over take).
        pend_d = en ? ((pend_q & ~take) | req) : pend_q;

        vld_d  = vld_q;
        code_d = code_q;
        if (load) begin
            vld_d  = 1'b1;
            code_d = sel;
        end else if (vld_q && out_ready) begin
            vld_d  = 1'b0;
        end

        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 8'h00;
            code_q <= 3'd0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            code_q <= code_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = vld_q;
    assign pending   = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_prio_encoder8.sv
// Directed bench for prio_encoder8 with hand-computed expectations.
module tb_prio_encoder8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       ovf;
    logic       ovf_clr;

    int checks   = 0;
    int failures = 0;

    prio_encoder8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c, input logic [7:0] p);
        chk({tag, "_valid"}, {7'd0, out_valid}, {7'd0, v});
        if (v) chk({tag, "_code"}, {5'd0, out_code}, {5'd0, c});
        chk({tag, "_pend"}, pending, p);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 8'hFF; out_ready = 1'b1; ovf_clr = 1'b0;

        // Reset and idle
        tick(); tick();
        chk("rst_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_code", {5'd0, out_code}, 8'h00);
        chk("rst_pend", pending, 8'h00);
        chk("rst_ovf", {7'd0, ovf}, 8'h00);
        rst_n = 1'b1; req = 8'h00;
        tick();
        chk_out("idle", 1'b0, 3'd0, 8'h00);

        // Single request
        req = 8'h08;
        tick();
        chk_out("single_e1", 1'b0, 3'd0, 8'h08);
        req = 8'h00;
        tick();
        chk_out("single_e2", 1'b1, 3'd3, 8'h00);
        tick();
        chk_out("single_e3", 1'b0, 3'd0, 8'h00);

        // Priority order, back-to-back
        req = 8'hA5;
        tick();
        chk_out("prio_cap", 1'b0, 3'd0, 8'hA5);
        req = 8'h00;
        tick(); chk_out("prio_7", 1'b1, 3'd7, 8'h25);
        tick(); chk_out("prio_5", 1'b1, 3'd5, 8'h05);
        tick(); chk_out("prio_2", 1'b1, 3'd2, 8'h01);
        tick(); chk_out("prio_0", 1'b1, 3'd0, 8'h00);
        tick(); chk_out("prio_end", 1'b0, 3'd0, 8'h00);

        // Single-hot sweep
        for (int i = 0; i < 8; i++) begin
            req = 8'h01 << i;
            tick();
            req = 8'h00;
            tick();
            chk_out("sweep", 1'b1, 3'(i), 8'h00);
            tick();
            chk_out("sweep_end", 1'b0, 3'd0, 8'h00);
        end

        // Stall and no preemption
        out_ready = 1'b0; req = 8'h02;
        tick();
        req = 8'h00;
        tick();
        chk_out("stall_load", 1'b1, 3'd1, 8'h00);
        req = 8'h80;
        tick();
        req = 8'h00;
        chk_out("stall_1", 1'b1, 3'd1, 8'h80);
        tick();
        chk_out("stall_2", 1'b1, 3'd1, 8'h80);
        tick();
        chk_out("stall_3", 1'b1, 3'd1, 8'h80);
        out_ready = 1'b1;
        tick();
        chk_out("stall_acc7", 1'b1, 3'd7, 8'h00);
        tick();
        chk_out("stall_end", 1'b0, 3'd0, 8'h00);

        // Overflow and clear
        out_ready = 1'b0; req = 8'h11;
        tick();
        chk_out("ovf_cap", 1'b0, 3'd0, 8'h11);
        req = 8'h00;
        tick();
        chk_out("ovf_load4", 1'b1, 3'd4, 8'h01);
        chk("ovf_pre", {7'd0, ovf}, 8'h00);
        req = 8'h01;
        tick();
        chk("ovf_set", {7'd0, ovf}, 8'h01);
        chk_out("ovf_hold", 1'b1, 3'd4, 8'h01);
        req = 8'h00; ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", {7'd0, ovf}, 8'h00);
        ovf_clr = 1'b0;

        // Request for the index in the output stage during its handshake re-pends
        out_ready = 1'b1; req = 8'h10;
        tick();
        chk_out("repend_hs", 1'b1, 3'd0, 8'h10);
        chk("repend_ovf", {7'd0, ovf}, 8'h00);
        // Same-cycle set and take of bit 4: set wins, no overflow
        tick();
        chk_out("setwin_take", 1'b1, 3'd4, 8'h10);
        chk("setwin_ovf", {7'd0, ovf}, 8'h00);
        req = 8'h00;
        tick();
        chk_out("setwin_again", 1'b1, 3'd4, 8'h00);
        tick();
        chk_out("setwin_end", 1'b0, 3'd0, 8'h00);

        // New overflow beats a simultaneous clear
        out_ready = 1'b0; req = 8'h01;
        tick();
        req = 8'h00;
        tick();
        chk_out("ovfclr_load", 1'b1, 3'd0, 8'h00);
        req = 8'h02;
        tick();
        chk_out("ovfclr_pend", 1'b1, 3'd0, 8'h02);
        chk("ovfclr_noovf", {7'd0, ovf}, 8'h00);
        ovf_clr = 1'b1;
        tick();
        chk("ovfclr_setwins", {7'd0, ovf}, 8'h01);
        req = 8'h00; ovf_clr = 1'b0; out_ready = 1'b1;
        tick();
        chk_out("ovfclr_acc1", 1'b1, 3'd1, 8'h00);
        tick();
        chk_out("ovfclr_end", 1'b0, 3'd0, 8'h00);
        chk("ovf_sticky", {7'd0, ovf}, 8'h01);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr2", {7'd0, ovf}, 8'h00);

        // Enable gating
        en = 1'b0; req = 8'hFF;
        tick(); tick(); tick();
        chk_out("en_off", 1'b0, 3'd0, 8'h00);
        chk("en_off_ovf", {7'd0, ovf}, 8'h00);
        en = 1'b1;
        tick();
        chk_out("en_cap", 1'b0, 3'd0, 8'hFF);
        req = 8'h00;
        tick();
        chk_out("en_load7", 1'b1, 3'd7, 8'h7F);
        // Handshake drains with en=0 but nothing new loads
        en = 1'b0;
        tick();
        chk_out("en_drain", 1'b0, 3'd0, 8'h7F);
        en = 1'b1; out_ready = 1'b0;
        tick();
        chk_out("en_load6", 1'b1, 3'd6, 8'h3F);

        // Reset mid-stall
        rst_n = 1'b0; req = 8'hFF;
        tick();
        chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
        chk("mid_rst_code", {5'd0, out_code}, 8'h00);
        chk("mid_rst_pend", pending, 8'h00);
        chk("mid_rst_ovf", {7'd0, ovf}, 8'h00);
        rst_n = 1'b1; req = 8'h00;
        tick();
        chk_out("post_rst", 1'b0, 3'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
